// File: rtl/cla_nibble_seq.sv
// Two-requester adder that time-shares one external 4-bit CLA slice.
// Each accepted operation takes WIDTH/4 slice passes, LSB nibble first.
module cla_nibble_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [4:0]       slice_s,
    output logic             res_valid,
    output logic [WIDTH:0]   res_sum,
    output logic             res_id,
    input  logic             res_ready
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_nibble_seq: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic [3:0]       r_slice_a;
    logic [3:0]       r_slice_b;
    logic             r_last_grant;
    logic             r_res_valid;
    logic [WIDTH:0]   r_res_sum;
    logic             r_res_id;

    logic             w_any_valid;
    logic             w_grant_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_last_nib;
    logic [WIDTH-1:0] w_acc_next;

    // Round-robin: on a tie the requester not granted last wins.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = (r_state == IDLE) && w_any_valid;

    assign req0_ready  = w_accept && !w_grant_id;
    assign req1_ready  = w_accept &&  w_grant_id;

    assign w_op_a      = w_grant_id ? req1_a : req0_a;
    assign w_op_b      = w_grant_id ? req1_b : req0_b;
    assign w_last_nib  = (r_k == KW'(NIB - 1));

    // Result nibbles enter at the top and shift down, so nibble 0 lands at bit 0.
    assign w_acc_next  = {slice_s[3:0], r_acc[WIDTH-1:4]};

    assign slice_a     = r_slice_a;
    assign slice_b     = r_slice_b;
    assign slice_cin   = r_carry;
    assign res_valid   = r_res_valid;
    assign res_sum     = r_res_sum;
    assign res_id      = r_res_id;

    // Operand registers shift right one nibble per pass; the slice drive is
    // preloaded one edge early so it is stable for the whole RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_k          <= '0;
            r_carry      <= 1'b0;
            r_slice_a    <= 4'd0;
            r_slice_b    <= 4'd0;
            r_last_grant <= 1'b1;
            r_res_valid  <= 1'b0;
            r_res_sum    <= '0;
            r_res_id     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_op_a >> 4;
                        r_b          <= w_op_b >> 4;
                        r_slice_a    <= w_op_a[3:0];
                        r_slice_b    <= w_op_b[3:0];
                        r_carry      <= 1'b0;
                        r_k          <= '0;
                        r_acc        <= '0;
                        r_res_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + KW'(1);
                    if (w_last_nib) begin
                        r_res_sum   <= {slice_s[4], w_acc_next};
                        r_res_valid <= 1'b1;
                        r_slice_a   <= 4'd0;
                        r_slice_b   <= 4'd0;
                        r_carry     <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_slice_a <= r_a[3:0];
                        r_slice_b <= r_b[3:0];
                        r_a       <= r_a >> 4;
                        r_b       <= r_b >> 4;
                        r_carry   <= slice_s[4];
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Randomised bench for cla_nibble_seq: models the slice, arbitration and
// expected sums with plain arithmetic and compares every cycle of each operation.
module tb_cla_nibble_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             req1_ready;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_cin;
    logic [4:0]       slice_s;
    logic             res_valid;
    logic [WIDTH:0]   res_sum;
    logic             res_id;
    logic             res_ready = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          model_last = 1'b1;

    always #5 clk = ~clk;

    // Behavioural 4-bit slice.
    assign slice_s = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    cla_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_s    (slice_s),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum",   64'(res_sum),   64'd0);
        chk("rst_id",    64'(res_id),    64'd0);
        chk("rst_slice", 64'({slice_a, slice_b, slice_cin}), 64'd0);
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        repeat (cycles) @(negedge clk);
        rst_n      = 1'b1;
        model_last = 1'b1;
    endtask

    // One full operation: grant check, per-pass slice checks, latency, result, hold, release.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                          input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                          input int hold, input bit keep);
        bit               g;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        logic [WIDTH:0]   es;
        logic [63:0]      m;
        g  = (v0 && v1) ? !model_last : v1;
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        es = (WIDTH+1)'(ea) + (WIDTH+1)'(eb);
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        chk("grant0", 64'(req0_ready), 64'(!g));
        chk("grant1", 64'(req1_ready), 64'(g));
        model_last = g;
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom);
        req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom);
        for (int k = 0; k < int'(NIB); k++) begin
            m = (64'd1 << (4 * k)) - 64'd1;
            chk("slice_a",   64'(slice_a),   (64'(ea) >> (4 * k)) & 64'hF);
            chk("slice_b",   64'(slice_b),   (64'(eb) >> (4 * k)) & 64'hF);
            chk("slice_cin", 64'(slice_cin), ((64'(ea) & m) + (64'(eb) & m)) >> (4 * k));
            chk("run_ready", 64'({req0_ready, req1_ready}), 64'd0);
            chk("run_valid", 64'(res_valid), 64'd0);
            res_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        res_ready = 1'b0;
        chk("latency", 64'(res_valid), 64'd1);
        chk("res_sum", 64'(res_sum),   64'(es));
        chk("res_id",  64'(res_id),    64'(g));
        chk("done_slice", 64'({slice_a, slice_b, slice_cin}), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_sum",   64'(res_sum),   64'(es));
            chk("hold_id",    64'(res_id),    64'(g));
            chk("hold_ready", 64'({req0_ready, req1_ready}), 64'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("release", 64'(res_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        run_op(1'b1, 1'b0, 16'h1234, 16'h4321, 16'h0, 16'h0, 0, 1'b0);
        run_op(1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 0, 1'b0);

        // Continuous contention after reset alternates req0, req1, req0.
        do_reset(2);
        for (int i = 0; i < 3; i++)
            run_op(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom),
                   WIDTH'($urandom), WIDTH'($urandom), 0, 1'b1);

        // Consumer stalls three cycles while both requesters wait.
        run_op(1'b1, 1'b1, 16'hABCD, 16'h9876, 16'h5A5A, 16'hA5A5, 3, 1'b1);

        // Reset mid-operation at k=2.
        do_reset(2);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        #1;
        chk("abort_grant", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_k2_a",   64'(slice_a),   64'hF);
        chk("abort_k2_cin", 64'(slice_cin), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(res_valid), 64'd0);
        chk("abort_slice", 64'({slice_a, slice_b, slice_cin}), 64'd0);
        chk("abort_sum",   64'(res_sum),   64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_hold", 64'(res_valid), 64'd0);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = 1'b1;
        repeat (NIB + 2) begin
            @(posedge clk); #1;
            chk("abort_none", 64'(res_valid), 64'd0);
        end
        run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            bit v0;
            bit v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_op(v0, v1, WIDTH'($urandom), WIDTH'($urandom),
                   WIDTH'($urandom), WIDTH'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cla_nibble_seq.md
CLA_NIBBLE_SEQ -- requirements
Module: cla_nibble_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; WIDTH SHALL be a multiple of 4, minimum 8.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-003 SHALL have port req0_valid input 1, requester 0 has an operation pending.
REQ-004 SHALL have port req0_a input WIDTH, requester 0 operand A.
REQ-005 SHALL have port req0_b input WIDTH, requester 0 operand B.
REQ-006 SHALL have port req0_ready output 1, requester 0 operands accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_a, req1_b, req1_ready, same as REQ-003..006 for requester 1.
REQ-008 SHALL have port slice_a output 4, nibble A driven to the shared 4-bit CLA slice.
REQ-009 SHALL have port slice_b output 4, nibble B driven to the slice.
REQ-010 SHALL have port slice_cin output 1, slice carry-in.
REQ-011 SHALL have port slice_s input 5, slice result; bit 4 is carry-out.
REQ-012 SHALL have port res_valid output 1, result available.
REQ-013 SHALL have port res_sum output WIDTH+1, A+B; MSB is final carry.
REQ-014 SHALL have port res_id output 1, index of the requester that owns res_sum.
REQ-015 SHALL have port res_ready input 1, consumer takes the result.

Function
REQ-016 SHALL use FSM states IDLE, RUN, DONE; NIB = WIDTH/4.
REQ-017 In IDLE, the block SHALL grant one valid requester per cycle, round-robin: if both are valid, it SHALL grant the one not granted last; if exactly one is valid, it SHALL grant that one.
REQ-018 reqX_ready SHALL be combinational, high only in IDLE for the granted requester; it SHALL be 0 in RUN and DONE.
REQ-019 On an accept edge, the block SHALL latch A, B and the requester id, update last_grant, clear the nibble index k and the carry register, and go to RUN.
REQ-020 In RUN, each cycle the block SHALL drive slice_a=A[4k+3:4k], slice_b=B[4k+3:4k] and slice_cin=carry (0 when k=0).
REQ-021 At each RUN edge, the block SHALL register slice_s[3:0] into sum bits [4k+3:4k], register slice_s[4] into carry, and increment k.
REQ-022 After the edge with k=NIB-1, the block SHALL set res_sum[WIDTH]=slice_s[4] and go to DONE.
REQ-023 Latency: res_valid SHALL rise exactly NIB cycles after the accept edge (4 cycles for WIDTH=16).
REQ-024 In IDLE and DONE, slice_a, slice_b and slice_cin SHALL be 0.
REQ-025 In DONE, res_valid SHALL be 1, and res_sum and res_id SHALL be held stable until res_ready=1.
REQ-026 On DONE with res_ready=1, the block SHALL go to IDLE; it SHALL NOT accept a new request in that same cycle (one bubble minimum between operations).
REQ-027 res_sum SHALL be exact modulo 2^(WIDTH+1); no overflow condition exists.
REQ-028 Changes on reqX_a and reqX_b after acceptance SHALL NOT affect the result.
REQ-029 res_ready while not in DONE SHALL be ignored.

Reset
REQ-030 While rst_n=0, the block SHALL force state IDLE, k=0, carry=0, res_valid=0, res_sum=0, res_id=0, slice outputs 0 and last_grant=1 (requester 0 wins first tie).
REQ-031 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no result emitted; after release, normal arbitration SHALL resume.

Verification
REQ-032 Reset -> all outputs 0; with req0_valid=req1_valid=0, both ready outputs SHALL be 0.
REQ-033 req0 A=0x1234, B=0x4321 -> req0_ready=1 for 1 cycle; 4 cycles later res_valid=1, res_sum=0x05555, res_id=0.
REQ-034 req1 A=0xFFFF, B=0x0001 -> res_sum=0x10000, res_id=1; slice_cin SHALL be 1 in RUN cycles k=1..3.
REQ-035 Both valid continuously after reset -> grants SHALL run req0, req1, req0, each result tagged with the matching id.
REQ-036 res_ready held 0 for 3 cycles in DONE -> res_valid and res_sum SHALL stay stable; both ready outputs SHALL stay 0; the result SHALL be released on the cycle res_ready=1.
REQ-037 rst_n pulsed low at k=2 of A=0xFFFF, B=0xFFFF -> res_valid SHALL never assert for that operation; the next request completes with correct value 0x1FFFE for the same operands.
